router_port_reader: RTL and testbench

//  Drains one router output port (vld_out/read_enb/data_out) and rebuilds whole packets:

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_rd_skid.sv | 55 +++++
 rtl/router_port_reader.sv | 141 ++++++++++++++
 tb/tb_router_port_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port reader.
//   rd_state_e : reader FSM states
//   beat_t     : one queued output beat {sop, eop, data}
//   header layout constants and payload limits
package router_pkg;

  typedef enum logic [1:0] {IDLE, HDR, BODY} rd_state_e;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int MAX_PAYLOAD = 63;
  localparam logic [HDR_ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

endpackage

// File: rtl/router_rd_skid.sv
// Small circular FIFO holding reassembled beats between the router read
// path and the downstream consumer.
//   clock : posedge clock
//   flush : synchronous clear (empties the queue)
//   push  : write din (caller guarantees space)
//   pop   : drop head entry (caller guarantees non-empty)
//   din   : beat to write
//   dout  : head beat (meaningful only when count != 0)
//   count : current occupancy
module router_rd_skid
  import router_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  beat_t                        din,
  output beat_t                        dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      // push+pop together leaves occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/router_port_reader.sv
// Drains one router output port and rebuilds packets into a framed byte
// stream: header (sop), payload, parity byte (eop). Checks parity, address
// and length, aborts stalled packets, and keeps saturating counters.
//   clock, reset         : posedge clock, synchronous active-high reset
//   vld_out, data_out    : router FIFO not-empty / read data (one cycle after read_enb)
//   read_enb             : router FIFO pop request
//   out_data/out_valid/out_ready/out_sop/out_eop : downstream beat handshake
//   pkt_done, parity_err, addr_err, len_err, pkt_abort : one-cycle event pulses
//   pkt_cnt, err_cnt     : saturating packet / error counters
module router_port_reader
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter int         SKID_DEPTH = 3,
  parameter int         TIMEOUT    = 30,
  parameter int         CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  output logic             read_enb,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             len_err,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int SCW = $clog2(SKID_DEPTH + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int RW  = $clog2(MAX_PAYLOAD + 2);

  rd_state_e      state, state_nx;
  logic [RW-1:0]  remaining;   // reads still to issue for this packet
  logic [RW-1:0]  body_left;   // captures still expected (payload + parity)
  logic [7:0]     par;
  logic           rd_inflight;
  logic [TW-1:0]  to_cnt;
  logic [SCW-1:0] skid_cnt;
  beat_t          skid_in, skid_out;
  logic           cap, hdr_cap, body_cap, last, to_inc, push, pop;
  logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len;
  logic [2:0]     ev;
  logic [CNT_W:0] err_sum;

  assign len = data_out[HDR_LEN_MSB:HDR_LEN_LSB];

  // Reads are budgeted against queue space including the byte still in flight,
  // so the skid queue can never overflow.
  assign read_enb = vld_out && (remaining != '0) &&
                    ((int'(skid_cnt) + int'(rd_inflight)) < SKID_DEPTH);

  assign to_inc    = (state != IDLE) && (remaining != '0) && !vld_out;
  assign pkt_abort = to_inc && (to_cnt == TW'(TIMEOUT - 1));

  // A byte arriving in the abort cycle is discarded.
  assign cap      = rd_inflight && !pkt_abort;
  assign hdr_cap  = cap && (state == HDR);
  assign body_cap = cap && (state == BODY);
  assign last     = body_cap && (body_left == RW'(1));

  assign pkt_done   = last;
  assign parity_err = last && (data_out != par);
  assign addr_err   = hdr_cap && (data_out[HDR_ADDR_W-1:0] != PORT_ID);
  assign len_err    = hdr_cap && (len == '0);

  assign push    = hdr_cap || body_cap;
  assign skid_in = '{sop: hdr_cap, eop: last, data: data_out};
  assign pop     = out_valid && out_ready;

  router_rd_skid #(.DEPTH(SKID_DEPTH)) u_skid (
    .clock (clock),
    .flush (reset),
    .push  (push),
    .pop   (pop),
    .din   (skid_in),
    .dout  (skid_out),
    .count (skid_cnt)
  );

  assign out_valid = (skid_cnt != '0);
  assign out_data  = out_valid ? skid_out.data : '0;
  assign out_sop   = out_valid && skid_out.sop;
  assign out_eop   = out_valid && skid_out.eop;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vld_out) state_nx = HDR;
      HDR:     if (hdr_cap) state_nx = BODY;
      BODY:    if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (pkt_abort) state_nx = IDLE;
  end

  assign ev      = 3'(parity_err) + 3'(addr_err) + 3'(len_err) + 3'(pkt_abort);
  assign err_sum = {1'b0, err_cnt} + {{(CNT_W-2){1'b0}}, ev};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      body_left   <= '0;
      par         <= '0;
      rd_inflight <= 1'b0;
      to_cnt      <= '0;
      pkt_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      rd_inflight <= read_enb;

      // Header read leaves remaining at 0, so no read overlaps the reload.
      if (pkt_abort)                  remaining <= '0;
      else if (state == IDLE && vld_out) remaining <= RW'(1);
      else if (hdr_cap)               remaining <= RW'(len) + 1'b1;
      else if (read_enb)              remaining <= remaining - 1'b1;

      if (hdr_cap)       body_left <= RW'(len) + 1'b1;
      else if (body_cap) body_left <= body_left - 1'b1;

      if (hdr_cap)                par <= data_out;
      else if (body_cap && !last) par <= par ^ data_out;

      if (read_enb || state == IDLE || pkt_abort) to_cnt <= '0;
      else if (to_inc)                            to_cnt <= to_cnt + 1'b1;

      if (pkt_done && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_router_port_reader.sv
// Randomized bench for router_port_reader: a router FIFO model feeds the DUT,
// a monitor records beats and pulses, and a packet-level model predicts the
// beat stream, event counts and counters.
module tb_router_port_reader;
  localparam logic [1:0] PORT_ID = 2'd0;
  localparam int CNT_W = 16;
  localparam int TIMEOUT = 30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic vld_out, read_enb, out_valid, out_ready = 1'b0, out_sop, out_eop;
  logic [7:0] data_out = 8'h00, out_data;
  logic pkt_done, parity_err, addr_err, len_err, pkt_abort;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  router_port_reader #(.PORT_ID(PORT_ID), .SKID_DEPTH(3), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out), .read_enb(read_enb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
    .len_err(len_err), .pkt_abort(pkt_abort), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt));

  always #5 clock = ~clock;

  // Router FIFO model: bytes written by the stimulus, popped on read_enb.
  logic [7:0] rmem [0:4095];
  int wp = 0, rp = 0, rdy_mode = 0;
  assign vld_out = (rp != wp);

  always @(posedge clock) begin
    if (reset) rp <= wp;
    else if (read_enb) begin data_out <= rmem[rp]; rp <= rp + 1; end
    case (rdy_mode)
      0: out_ready <= 1'b1;
      1: out_ready <= ~out_ready;
      2: out_ready <= 1'($urandom_range(0, 1));
      default: out_ready <= 1'b0;
    endcase
  end

  // Monitor
  logic [9:0] got [0:4095];
  int gn = 0, outst = 0;
  int n_done = 0, n_perr = 0, n_aerr = 0, n_lerr = 0, n_abort = 0;
  always @(negedge clock) begin
    if (reset) outst = 0;
    else begin
      if (out_valid && out_ready) begin got[gn] = {out_sop, out_eop, out_data}; gn++; outst--; end
      if (read_enb) outst++;
      if (pkt_done) n_done++;
      if (pkt_done && parity_err) n_perr++;
      if (addr_err) n_aerr++;
      if (len_err) n_lerr++;
      if (pkt_abort) n_abort++;
    end
  end

  // Model state
  logic [9:0] exp_q [$];
  int base = 0, exp_pkt = 0, exp_err = 0;
  int exp_done = 0, exp_perr = 0, exp_aerr = 0, exp_lerr = 0, exp_abort = 0;
  int n_cmp = 0, n_fail = 0;

  task automatic push_byte(input logic [7:0] b);
    rmem[wp] = b;
    wp = wp + 1;
  endtask

  // Sends header + npay payload bytes; a parity byte follows only when npay == len,
  // otherwise the packet is expected to time out.
  task automatic send_pkt(input logic [7:0] h, input int npay, input bit bad);
    int len;
    logic [7:0] x, b;
    len = int'(h[7:2]);
    x = h;
    push_byte(h); exp_q.push_back({2'b10, h});
    if (h[1:0] != PORT_ID) begin exp_aerr++; exp_err++; end
    if (len == 0) begin exp_lerr++; exp_err++; end
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom); x = x ^ b;
      push_byte(b); exp_q.push_back({2'b00, b});
    end
    if (npay == len) begin
      b = bad ? ~x : x;
      push_byte(b); exp_q.push_back({2'b01, b});
      exp_done++; exp_pkt++;
      if (bad) begin exp_perr++; exp_err++; end
    end else begin
      exp_abort++; exp_err++;
    end
  endtask

  task automatic wait_drain(input int n, output bit ok);
    int c;
    c = 0;
    while ((gn - base) < n && c < 3000) begin @(posedge clock); c++; end
    ok = ((gn - base) >= n);
    repeat (4) @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({read_enb, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, len_err, pkt_abort} !== 9'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0", {read_enb, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, len_err, pkt_abort});
    end
    n_cmp++;
    if (out_data !== 8'h00 || pkt_cnt !== '0 || err_cnt !== '0) begin
      n_fail++; $display("FAIL reset_data got data=%h pkt=%0d err=%0d want 0", out_data, pkt_cnt, err_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int tre, tov;
    bit ok;
    tre = -1; tov = -1;
    rdy_mode = 0;
    @(negedge clock);
    send_pkt(8'h30, 12, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (read_enb && tre < 0) tre = c;
      if (out_valid && tov < 0) tov = c;
    end
    n_cmp++;
    if (tre < 0 || tov - tre != 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", tov - tre); end
    wait_drain(exp_q.size(), ok);
    n_cmp++;
    if (!ok || gn - base != exp_q.size()) begin n_fail++; $display("FAIL basic_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if ({n_done, n_perr, n_aerr, n_lerr, n_abort} !== {exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort}) begin
      n_fail++; $display("FAIL basic_pulses got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", n_done, n_perr, n_aerr, n_lerr, n_abort, exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort);
    end
    n_cmp++;
    if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL basic_counters got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
  endtask

  // Parity corruption plus header address/length errors, all fully drained.
  task automatic test_errors();
    bit ok;
    @(negedge clock);
    send_pkt(8'h30, 12, 1'b1);
    send_pkt(8'h05, 1, 1'b0);
    send_pkt(8'h00, 0, 1'b0);
    wait_drain(exp_q.size(), ok);
    n_cmp++;
    if (!ok || gn - base != exp_q.size()) begin n_fail++; $display("FAIL err_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL err_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if ({n_done, n_perr, n_aerr, n_lerr, n_abort} !== {exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort}) begin
      n_fail++; $display("FAIL err_pulses got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", n_done, n_perr, n_aerr, n_lerr, n_abort, exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort);
    end
    n_cmp++;
    if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL err_counters got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
  endtask

  task automatic test_backpressure();
    int mx, c;
    mx = 0; c = 0;
    rdy_mode = 1;
    @(negedge clock);
    send_pkt(8'h40, 16, 1'b0);
    while ((gn - base) < exp_q.size() && c < 500) begin
      @(posedge clock); c++;
      if (outst > mx) mx = outst;
    end
    repeat (4) @(posedge clock);
    n_cmp++;
    if (mx > 3) begin n_fail++; $display("FAIL bp_occupancy got %0d want <=3", mx); end
    n_cmp++;
    if (gn - base != exp_q.size()) begin n_fail++; $display("FAIL bp_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL bp_counters got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
  endtask

  task automatic test_abort();
    int tlast, tab;
    bit ok;
    tlast = -1; tab = -1;
    rdy_mode = 0;
    @(negedge clock);
    send_pkt(8'h44, 5, 1'b0);
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      if (read_enb) tlast = c;
      if (pkt_abort && tab < 0) tab = c;
    end
    n_cmp++;
    if (tab < 0 || tab - tlast != TIMEOUT) begin n_fail++; $display("FAIL abort_timing got %0d want %0d", tab - tlast, TIMEOUT); end
    @(posedge clock);
    n_cmp++;
    if (gn - base != exp_q.size()) begin n_fail++; $display("FAIL abort_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    // Following packet must be received cleanly.
    @(negedge clock);
    send_pkt(8'h18, 6, 1'b0);
    wait_drain(exp_q.size(), ok);
    n_cmp++;
    if (!ok || gn - base != exp_q.size()) begin n_fail++; $display("FAIL abort_next_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_next_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if ({n_done, n_abort} !== {exp_done, exp_abort} || pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL abort_counts got done=%0d abort=%0d pkt=%0d err=%0d want %0d/%0d/%0d/%0d", n_done, n_abort, pkt_cnt, err_cnt, exp_done, exp_abort, exp_pkt, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [1:0] a;
    bit ok;
    rdy_mode = 2;
    @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(0, 20);
      a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : PORT_ID;
      send_pkt({6'(len), a}, len, $urandom_range(0, 3) == 0);
    end
    wait_drain(exp_q.size(), ok);
    n_cmp++;
    if (!ok || gn - base != exp_q.size()) begin n_fail++; $display("FAIL b2b_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if ({n_done, n_perr, n_aerr, n_lerr, n_abort} !== {exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort}) begin
      n_fail++; $display("FAIL b2b_pulses got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", n_done, n_perr, n_aerr, n_lerr, n_abort, exp_done, exp_perr, exp_aerr, exp_lerr, exp_abort);
    end
    n_cmp++;
    if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL b2b_counters got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rdy_mode = 3;
    @(negedge clock);
    push_byte(8'hFC);
    for (int i = 0; i < 63; i++) push_byte(8'($urandom));
    repeat (10) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_before got %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({read_enb, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, len_err, pkt_abort} !== 9'b0 ||
        out_data !== 8'h00 || pkt_cnt !== '0 || err_cnt !== '0) begin
      n_fail++; $display("FAIL rmid_outputs got flags=%b data=%h pkt=%0d err=%0d want 0", {read_enb, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, len_err, pkt_abort}, out_data, pkt_cnt, err_cnt);
    end
    reset = 1'b0;
    exp_pkt = 0; exp_err = 0; base = gn; exp_q.delete();
    rdy_mode = 0;
    @(negedge clock);
    send_pkt(8'hFC, 63, 1'b0);
    wait_drain(exp_q.size(), ok);
    n_cmp++;
    if (!ok || gn - base != exp_q.size()) begin n_fail++; $display("FAIL rmid_beats got %0d want %0d", gn - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < gn - base; i++) begin
      n_cmp++;
      if (got[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_beat%0d got %h want %h", i, got[base + i], exp_q[i]); end
    end
    base = gn; exp_q.delete();
    n_cmp++;
    if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_err)) begin
      n_fail++; $display("FAIL rmid_counters got %0d/%0d want %0d/%0d", pkt_cnt, err_cnt, exp_pkt, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
